// File: rtl/ysyx_25040129_pkg.sv
// ysyx_25040129_pkg: shared widths and constants for the issue-stage slice
package ysyx_25040129_pkg;
    localparam int REGS_DIG = 4;
    localparam int XLEN     = 32;
    localparam int CTRL_W   = 16;
    localparam int NREGS    = 1 << REGS_DIG;
    localparam logic [REGS_DIG-1:0] ZERO_ID = '0;
endpackage

// File: rtl/ysyx_25040129_scoreboard.sv
// ysyx_25040129_scoreboard: busy bit per register with set/clear/flush-clear and a 3-id lookup
module ysyx_25040129_scoreboard
    import ysyx_25040129_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         set_en,
    input  logic [REGS_DIG-1:0]          set_id,
    input  logic                         clr_en,
    input  logic [REGS_DIG-1:0]          clr_id,
    input  logic                         fclr_en,
    input  logic [REGS_DIG-1:0]          fclr_id,
    input  logic [2:0][REGS_DIG-1:0]     q_id,
    output logic [2:0]                   q_busy,
    output logic [NREGS-1:0]             busy
);
    logic [NREGS-1:0] busy_next;
    // clears first so a same-cycle set of the same register wins; x0 is never busy
    always_comb begin
        busy_next = busy;
        if (clr_en) busy_next[clr_id] = 1'b0;
        if (fclr_en) busy_next[fclr_id] = 1'b0;
        if (set_en) busy_next[set_id] = 1'b1;
        busy_next[ZERO_ID] = 1'b0;
    end
    // busy lookup for rs1, rs2, rd
    always_comb begin
        q_busy = '0;
        for (int i = 0; i < 3; i++) q_busy[i] = busy[q_id[i]];
    end
    // busy register; a writeback to an idle register is flagged in simulation
    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else begin
            assert (!clr_en || clr_id == ZERO_ID || busy[clr_id])
                else $warning("scoreboard: writeback to idle register x%0d", clr_id);
            busy <= busy_next;
        end
    end
endmodule

// File: rtl/ysyx_25040129_operand_fetch.sv
// ysyx_25040129_operand_fetch: hazard-checked operand fetch and issue register toward the EXU
module ysyx_25040129_operand_fetch
    import ysyx_25040129_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     in_pc,
    input  logic [CTRL_W-1:0]   in_ctrl,
    input  logic [REGS_DIG-1:0] in_rs1,
    input  logic [REGS_DIG-1:0] in_rs2,
    input  logic                in_use_rs1,
    input  logic                in_use_rs2,
    input  logic [REGS_DIG-1:0] in_rd,
    input  logic                in_rd_we,
    output logic [REGS_DIG-1:0] rf_src1_id,
    output logic [REGS_DIG-1:0] rf_src2_id,
    input  logic [XLEN-1:0]     rf_src1,
    input  logic [XLEN-1:0]     rf_src2,
    output logic [REGS_DIG-1:0] rf_rd,
    output logic                rf_reg_write,
    output logic [XLEN-1:0]     rf_result,
    input  logic                wb_valid,
    input  logic [REGS_DIG-1:0] wb_rd,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [CTRL_W-1:0]   out_ctrl,
    output logic [REGS_DIG-1:0] out_rd,
    output logic                out_rd_we,
    output logic [XLEN-1:0]     out_src1,
    output logic [XLEN-1:0]     out_src2
);
    logic [2:0]       q_busy;
    logic [NREGS-1:0] busy;
    logic             raw1, raw2, waw, issue;
    logic             wb_hit1, wb_hit2, wb_hitd;
    logic [XLEN-1:0]  op1, op2;

    assign rf_src1_id   = in_rs1;
    assign rf_src2_id   = in_rs2;
    assign rf_rd        = wb_rd;
    assign rf_reg_write = wb_valid;
    assign rf_result    = wb_data;

    ysyx_25040129_scoreboard u_sb (
        .clk     (clk),
        .rst     (rst),
        .set_en  (issue && in_rd_we && in_rd != ZERO_ID),
        .set_id  (in_rd),
        .clr_en  (wb_valid && wb_rd != ZERO_ID),
        .clr_id  (wb_rd),
        .fclr_en (flush && out_valid && out_rd_we && out_rd != ZERO_ID),
        .fclr_id (out_rd),
        .q_id    ({in_rd, in_rs2, in_rs1}),
        .q_busy  (q_busy),
        .busy    (busy)
    );

    // hazards are waived when the same-cycle writeback resolves them; operands bypass that writeback
    always_comb begin
        wb_hit1  = wb_valid && wb_rd == in_rs1;
        wb_hit2  = wb_valid && wb_rd == in_rs2;
        wb_hitd  = wb_valid && wb_rd == in_rd;
        raw1     = in_use_rs1 && in_rs1 != ZERO_ID && q_busy[0] && !wb_hit1;
        raw2     = in_use_rs2 && in_rs2 != ZERO_ID && q_busy[1] && !wb_hit2;
        waw      = in_rd_we && in_rd != ZERO_ID && q_busy[2] && !wb_hitd;
        in_ready = (!out_valid || out_ready) && !raw1 && !raw2 && !waw && !flush;
        issue    = in_valid && in_ready;
        op1      = in_rs1 == ZERO_ID ? '0 : wb_hit1 ? wb_data : rf_src1;
        op2      = in_rs2 == ZERO_ID ? '0 : wb_hit2 ? wb_data : rf_src2;
    end

    // issue register: flush empties it, issue loads it, an EXU accept drains it
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_ctrl  <= '0;
            out_rd    <= '0;
            out_rd_we <= 1'b0;
            out_src1  <= '0;
            out_src2  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (issue) begin
            out_valid <= 1'b1;
            out_pc    <= in_pc;
            out_ctrl  <= in_ctrl;
            out_rd    <= in_rd;
            out_rd_we <= in_rd_we;
            out_src1  <= op1;
            out_src2  <= op2;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
